// File: rtl/capture_pkg.sv
// Shared types and constants for the capture/trigger engine.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    ARMED,
    POST,
    HOLD
  } state_t;

  localparam logic [1:0] MODE_AUTO   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/capture_trigger_ctrl_trig_detect.sv
// Edge trigger with hysteresis on one selected channel, plus the auto-mode
// timeout counter that forces a trigger after AUTO_TIMEOUT armed samples.
module trig_detect
  import capture_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int DW           = 8,
  parameter int TCW          = 1,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              valid,
  input  logic [NCH*DW-1:0] sample_data,
  input  logic [TCW-1:0]    trig_ch,
  input  logic [DW-1:0]     trig_level,
  input  logic [DW-1:0]     trig_hyst,
  input  logic              trig_edge,
  input  logic              tmo_en,
  output logic              fire,
  output logic              timeout
);

  localparam int CW = $clog2(AUTO_TIMEOUT + 1);

  logic [DW-1:0]  s;
  logic [DW-1:0]  thr_lo;
  logic [DW-1:0]  thr_hi;
  logic [DW:0]    sum;
  logic           flag;
  logic           flag_eff;
  logic           arm_hit;
  logic           fire_hit;
  logic           cfg_chg;
  logic [TCW-1:0] ch_q;
  logic           edge_q;
  logic [CW-1:0]  tmo_cnt;

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    s = sample_data[DW-1:0];
    for (int unsigned k = 1; k < NCH; k++) begin
      if (32'(trig_ch) == k) s = sample_data[k*DW +: DW];
    end
  end

  always_comb begin
    thr_lo   = (trig_level > trig_hyst) ? trig_level - trig_hyst : '0;
    sum      = {1'b0, trig_level} + {1'b0, trig_hyst};
    thr_hi   = sum[DW] ? '1 : sum[DW-1:0];
    arm_hit  = (trig_edge == EDGE_RISE) ? (s <= thr_lo) : (s >= thr_hi);
    fire_hit = (trig_edge == EDGE_RISE) ? (s >= trig_level) : (s <= trig_level);
    cfg_chg  = (trig_ch != ch_q) || (trig_edge != edge_q);
    // Fire uses the flag from earlier samples only, so one sample cannot both arm and fire.
    flag_eff = flag && !cfg_chg;
    fire     = valid && flag_eff && fire_hit;
    timeout  = valid && tmo_en && (tmo_cnt == CW'(AUTO_TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag    <= 1'b0;
      tmo_cnt <= '0;
      ch_q    <= '0;
      edge_q  <= 1'b0;
    end else begin
      ch_q   <= trig_ch;
      edge_q <= trig_edge;
      if (clr || cfg_chg) flag <= 1'b0;
      else if (valid && arm_hit) flag <= 1'b1;
      if (clr) tmo_cnt <= '0;
      else if (valid && tmo_en) tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/capture_trigger_ctrl.sv
// Capture engine: circular frame buffer, pre/post-trigger sequencing and
// trigger-aligned readout for the waveform renderer.
module capture_trigger_ctrl
  import capture_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int DW           = 8,
  parameter int AW           = 11,
  parameter int TCW          = 1,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [NCH*DW-1:0] sample_data,
  input  logic [TCW-1:0]    trig_ch,
  input  logic [DW-1:0]     trig_level,
  input  logic [DW-1:0]     trig_hyst,
  input  logic              trig_edge,
  input  logic [1:0]        trig_mode,
  input  logic              pause,
  input  logic              arm,
  input  logic [AW-1:0]     pre_len,
  output logic              frame_ready,
  input  logic              frame_done,
  input  logic [AW-1:0]     rd_addr,
  output logic [NCH*DW-1:0] rd_data,
  output logic [AW-1:0]     trig_pos,
  output logic              forced,
  output logic              busy
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] PRE_MAX = {{(AW-1){1'b1}}, 1'b0};

  state_t state;
  state_t state_next;

  logic [NCH*DW-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     pre_len_q;
  logic [AW-1:0]     pre_cnt;
  logic [AW-1:0]     post_cnt;
  logic [AW-1:0]     start_ptr;
  logic [1:0]        mode_q;
  logic              done_pend;
  logic              wr_en;
  logic              enter_pre;
  logic              mode_latch;
  logic              det_valid;
  logic              tmo_en;
  logic              fire;
  logic              timeout;

  trig_detect #(
    .NCH          (NCH),
    .DW           (DW),
    .TCW          (TCW),
    .AUTO_TIMEOUT (AUTO_TIMEOUT)
  ) u_trig (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (enter_pre),
    .valid       (det_valid),
    .sample_data (sample_data),
    .trig_ch     (trig_ch),
    .trig_level  (trig_level),
    .trig_hyst   (trig_hyst),
    .trig_edge   (trig_edge),
    .tmo_en      (tmo_en),
    .fire        (fire),
    .timeout     (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (trig_mode != MODE_SINGLE || arm) state_next = PREFILL;
      PREFILL: if (pre_len_q == '0 || (sample_valid && pre_cnt == pre_len_q - 1'b1))
                 state_next = ARMED;
      ARMED:   if (fire || timeout) state_next = POST;
      POST:    if (sample_valid && post_cnt == AW'(1)) state_next = HOLD;
      HOLD:    if ((frame_done || done_pend) && !pause)
                 state_next = (trig_mode == MODE_SINGLE) ? IDLE : PREFILL;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == PREFILL) || (state == ARMED) || (state == POST);
    wr_en      = busy && sample_valid;
    enter_pre  = (state_next == PREFILL) && (state != PREFILL);
    mode_latch = ((state == IDLE) || (state == HOLD)) && (state_next != state);
    det_valid  = sample_valid && (state == ARMED);
    // Mode is latched per frame, but dropping out of auto stops the timeout immediately.
    tmo_en     = (mode_q == MODE_AUTO) && (trig_mode == MODE_AUTO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      pre_len_q   <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      trig_pos    <= '0;
      forced      <= 1'b0;
      frame_ready <= 1'b0;
      done_pend   <= 1'b0;
      mode_q      <= MODE_AUTO;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (enter_pre) begin
        pre_len_q <= (pre_len > PRE_MAX) ? PRE_MAX : pre_len;
        pre_cnt   <= '0;
      end else if (state == PREFILL && sample_valid) begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      // DEPTH - pre_len_q - 1 is the bitwise complement in AW bits.
      if (state == ARMED && (fire || timeout)) begin
        trig_pos <= wr_ptr;
        forced   <= !fire;
        post_cnt <= ~pre_len_q;
      end else if (state == POST && sample_valid) begin
        post_cnt <= post_cnt - 1'b1;
      end
      frame_ready <= (state_next == HOLD);
      if (state == HOLD && state_next == HOLD) begin
        if (frame_done && pause) done_pend <= 1'b1;
      end else begin
        done_pend <= 1'b0;
      end
      if (mode_latch) mode_q <= trig_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_data;
  end

  assign start_ptr = trig_pos - pre_len_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[start_ptr + rd_addr];
  end

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Self-checking bench for capture_trigger_ctrl against a sample-list reference model.
`timescale 1ns/1ps
module tb_capture_trigger_ctrl;

  localparam int NCH   = 2;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int TCW   = 1;
  localparam int ATO   = 32;
  localparam int DEPTH = 16;
  localparam int PMAX  = 14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_valid = 1'b0;
  logic [NCH*DW-1:0] sample_data = '0;
  logic [TCW-1:0]    trig_ch = '0;
  logic [DW-1:0]     trig_level = 8'd128;
  logic [DW-1:0]     trig_hyst = 8'd8;
  logic              trig_edge = 1'b0;
  logic [1:0]        trig_mode = 2'd1;
  logic              pause = 1'b0;
  logic              arm = 1'b0;
  logic [AW-1:0]     pre_len = 4'd4;
  logic              frame_ready;
  logic              frame_done = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic [NCH*DW-1:0] rd_data;
  logic [AW-1:0]     trig_pos;
  logic              forced;
  logic              busy;

  int checks = 0;
  int failures = 0;
  int wcount = 0;
  int lvl = 128;
  int hys = 8;
  int stim0[$];
  int stim1[$];

  always #5 clk = ~clk;

  capture_trigger_ctrl #(
    .NCH          (NCH),
    .DW           (DW),
    .AW           (AW),
    .TCW          (TCW),
    .AUTO_TIMEOUT (ATO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_ch      (trig_ch),
    .trig_level   (trig_level),
    .trig_hyst    (trig_hyst),
    .trig_edge    (trig_edge),
    .trig_mode    (trig_mode),
    .pause        (pause),
    .arm          (arm),
    .pre_len      (pre_len),
    .frame_ready  (frame_ready),
    .frame_done   (frame_done),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .trig_pos     (trig_pos),
    .forced       (forced),
    .busy         (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: scan the sample list from the first armed sample using the trigger rules.
  function automatic void model(input int pq, input int ch, input bit fall, input bit auto_m,
                                output int t, output bit frc);
    int lo, hi, s, cnt;
    bit flag, hit;
    lo = (lvl > hys) ? lvl - hys : 0;
    hi = (lvl + hys > 255) ? 255 : lvl + hys;
    t = -1; frc = 1'b0; flag = 1'b0; cnt = 0;
    for (int i = pq; i < stim0.size(); i++) begin
      s = (ch == 1) ? stim1[i] : stim0[i];
      cnt++;
      hit = fall ? (s <= lvl) : (s >= lvl);
      if (flag && hit) begin t = i; frc = 1'b0; return; end
      if (auto_m && cnt == ATO) begin t = i; frc = 1'b1; return; end
      if (fall ? (s >= hi) : (s <= lo)) flag = 1'b1;
    end
  endfunction

  task automatic push(input int a, input int b);
    sample_valid = 1'b1;
    sample_data  = {8'(b), 8'(a)};
    @(negedge clk);
    sample_valid = 1'b0;
    sample_data  = 16'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic configure(input int pl, input int ch, input bit fall, input int mode,
                           input int level, input int hyst);
    pre_len    = AW'(pl);
    trig_ch    = TCW'(ch);
    trig_edge  = fall;
    trig_mode  = 2'(mode);
    lvl        = level;
    hys        = hyst;
    trig_level = DW'(level);
    trig_hyst  = DW'(hyst);
  endtask

  task automatic read_word(input int a, output logic [15:0] d);
    rd_addr = AW'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic release_frame(input bit exp_busy);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    checks++;
    if (frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL release_ready: frame_ready=%b expected 0", frame_ready);
    end
    checks++;
    if (busy !== exp_busy) begin
      failures++;
      $display("FAIL release_busy: busy=%b expected %b", busy, exp_busy);
    end
    @(negedge clk);
  endtask

  task automatic do_capture(input int pq, input int ch, input bit fall, input bit auto_m);
    int t, last, base;
    bit frc, exp_rdy;
    logic [15:0] d;
    model(pq, ch, fall, auto_m, t, frc);
    base = wcount;
    last = (t < 0) ? stim0.size() - 1 : t + DEPTH - pq - 1;
    for (int i = 0; i <= last; i++) begin
      push(stim0[i], stim1[i]);
      wcount++;
      exp_rdy = (t >= 0) && (i == last);
      checks++;
      if (frame_ready !== exp_rdy) begin
        failures++;
        $display("FAIL frame_ready_seq: after sample %0d frame_ready=%b expected %b", i, frame_ready, exp_rdy);
      end
    end
    if (t < 0) return;
    checks++;
    if (forced !== frc) begin
      failures++;
      $display("FAIL forced: got %b expected %b", forced, frc);
    end
    checks++;
    if (trig_pos !== AW'((base + t) % DEPTH)) begin
      failures++;
      $display("FAIL trig_pos: got %0d expected %0d", trig_pos, (base + t) % DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      read_word(k, d);
      checks++;
      if (d !== {8'(stim1[t - pq + k]), 8'(stim0[t - pq + k])}) begin
        failures++;
        $display("FAIL frame_data: rd_addr %0d got %h expected %h", k, d,
                 {8'(stim1[t - pq + k]), 8'(stim0[t - pq + k])});
      end
    end
  endtask

  task automatic test_reset();
    configure(4, 0, 1'b0, 1, 128, 8);
    rst_n = 1'b0;
    sample_valid = 1'b1;
    sample_data = 16'h5a5a;
    repeat (3) @(negedge clk);
    sample_valid = 1'b0;
    checks++;
    if (frame_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", frame_ready); end
    checks++;
    if (forced !== 1'b0) begin failures++; $display("FAIL reset_forced: got %b expected 0", forced); end
    checks++;
    if (trig_pos !== '0) begin failures++; $display("FAIL reset_trig_pos: got %0d expected 0", trig_pos); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    rst_n = 1'b1;
    wcount = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_exit_busy: got %b expected 1", busy); end
    @(negedge clk);
  endtask

  task automatic test_rising();
    logic [15:0] d;
    stim0.delete(); stim1.delete();
    for (int i = 0; i < 40; i++) begin
      stim0.push_back(100 + i);
      stim1.push_back($urandom_range(0, 255));
    end
    do_capture(4, 0, 1'b0, 1'b0);
    read_word(4, d);
    checks++;
    if (d[7:0] !== 8'd128) begin failures++; $display("FAIL rise_addr4: got %0d expected 128", d[7:0]); end
    read_word(0, d);
    checks++;
    if (d[7:0] !== 8'd124) begin failures++; $display("FAIL rise_addr0: got %0d expected 124", d[7:0]); end
    read_word(15, d);
    checks++;
    if (d[7:0] !== 8'd139) begin failures++; $display("FAIL rise_addr15: got %0d expected 139", d[7:0]); end
  endtask

  task automatic test_hysteresis();
    logic [15:0] d;
    configure(4, 0, 1'b0, 1, 128, 8);
    release_frame(1'b1);
    stim0.delete(); stim1.delete();
    for (int i = 0; i < 4; i++) begin stim0.push_back($urandom_range(0, 255)); stim1.push_back($urandom_range(0, 255)); end
    stim0.push_back(110); stim1.push_back($urandom_range(0, 255));
    stim0.push_back(129); stim1.push_back($urandom_range(0, 255));
    for (int i = 0; i < 11; i++) begin stim0.push_back($urandom_range(0, 255)); stim1.push_back($urandom_range(0, 255)); end
    do_capture(4, 0, 1'b0, 1'b0);
    read_word(4, d);
    checks++;
    if (d[7:0] !== 8'd129) begin failures++; $display("FAIL hyst_trig_value: got %0d expected 129", d[7:0]); end
    release_frame(1'b1);
    stim0.delete(); stim1.delete();
    for (int i = 0; i < 204; i++) begin
      stim0.push_back((i % 2 == 0) ? 125 : 130);
      stim1.push_back($urandom_range(0, 255));
    end
    stim0.push_back(110); stim1.push_back($urandom_range(0, 255));
    stim0.push_back(130); stim1.push_back($urandom_range(0, 255));
    for (int i = 0; i < 11; i++) begin stim0.push_back($urandom_range(0, 255)); stim1.push_back($urandom_range(0, 255)); end
    do_capture(4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_auto();
    logic [15:0] d;
    configure(4, 0, 1'b0, 0, 128, 8);
    release_frame(1'b1);
    stim0.delete(); stim1.delete();
    for (int i = 0; i < 4 + ATO + 11; i++) begin stim0.push_back(50); stim1.push_back($urandom_range(0, 255)); end
    do_capture(4, 0, 1'b0, 1'b1);
    read_word(4, d);
    checks++;
    if (d[7:0] !== 8'd50) begin failures++; $display("FAIL auto_addr4: got %0d expected 50", d[7:0]); end
  endtask

  task automatic test_falling();
    logic [15:0] d;
    configure(4, 1, 1'b1, 1, 128, 8);
    release_frame(1'b1);
    stim0.delete(); stim1.delete();
    for (int i = 0; i < 17; i++) stim0.push_back($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) stim1.push_back($urandom_range(0, 255));
    stim1.push_back(140);
    stim1.push_back(127);
    for (int i = 0; i < 11; i++) stim1.push_back($urandom_range(0, 255));
    do_capture(4, 1, 1'b1, 1'b0);
    read_word(4, d);
    checks++;
    if (d[15:8] !== 8'd127) begin failures++; $display("FAIL fall_trig_value: got %0d expected 127", d[15:8]); end
  endtask

  task automatic test_random();
    int pl, pq, ch, lv, hy;
    bit fall;
    for (int n = 0; n < 4; n++) begin
      pl = $urandom_range(0, 15);
      pq = (pl > PMAX) ? PMAX : pl;
      ch = $urandom_range(0, 1);
      fall = 1'($urandom_range(0, 1));
      lv = $urandom_range(0, 255);
      hy = (n == 0) ? 0 : $urandom_range(0, 255);
      configure(pl, ch, fall, 1, lv, hy);
      release_frame(1'b1);
      stim0.delete(); stim1.delete();
      for (int i = 0; i < pq + 250; i++) begin stim0.push_back($urandom_range(0, 255)); stim1.push_back($urandom_range(0, 255)); end
      if (ch == 1) begin
        stim0.push_back($urandom_range(0, 255)); stim1.push_back(fall ? 255 : 0);
        stim0.push_back($urandom_range(0, 255)); stim1.push_back(lv);
      end else begin
        stim0.push_back(fall ? 255 : 0); stim1.push_back($urandom_range(0, 255));
        stim0.push_back(lv);             stim1.push_back($urandom_range(0, 255));
      end
      for (int i = 0; i < 16; i++) begin stim0.push_back($urandom_range(0, 255)); stim1.push_back($urandom_range(0, 255)); end
      do_capture(pq, ch, fall, 1'b0);
    end
  endtask

  task automatic build_clamp_stim();
    stim0.delete(); stim1.delete();
    for (int i = 0; i < PMAX; i++) begin stim0.push_back($urandom_range(0, 255)); stim1.push_back($urandom_range(0, 255)); end
    stim0.push_back(100); stim1.push_back($urandom_range(0, 255));
    stim0.push_back(130); stim1.push_back($urandom_range(0, 255));
    stim0.push_back($urandom_range(0, 255)); stim1.push_back($urandom_range(0, 255));
  endtask

  task automatic test_pause_clamp();
    logic [15:0] d;
    configure(15, 0, 1'b0, 1, 128, 8);
    release_frame(1'b1);
    build_clamp_stim();
    do_capture(PMAX, 0, 1'b0, 1'b0);
    read_word(14, d);
    checks++;
    if (d[7:0] !== 8'd130) begin failures++; $display("FAIL clamp_addr14: got %0d expected 130", d[7:0]); end
    pause = 1'b1;
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (frame_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL pause_hold: cycle %0d frame_ready=%b busy=%b expected 1/0", i, frame_ready, busy);
      end
      @(negedge clk);
    end
    pause = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pause_release: frame_ready=%b busy=%b expected 0/1", frame_ready, busy);
    end
    @(negedge clk);
    build_clamp_stim();
    do_capture(PMAX, 0, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    configure(4, 0, 1'b0, 2, 128, 8);
    release_frame(1'b0);
    for (int i = 0; i < 100; i++) begin
      sample_valid = 1'($urandom_range(0, 1));
      sample_data = 16'($urandom);
      frame_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (frame_ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL single_idle: cycle %0d frame_ready=%b busy=%b expected 0/0", i, frame_ready, busy);
      end
    end
    sample_valid = 1'b0;
    frame_done = 1'b0;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_arm: busy=%b expected 1", busy); end
    @(negedge clk);
    stim0.delete(); stim1.delete();
    for (int i = 0; i < 4; i++) begin stim0.push_back($urandom_range(0, 255)); stim1.push_back($urandom_range(0, 255)); end
    stim0.push_back(110); stim1.push_back($urandom_range(0, 255));
    stim0.push_back(129); stim1.push_back($urandom_range(0, 255));
    for (int i = 0; i < 11; i++) begin stim0.push_back($urandom_range(0, 255)); stim1.push_back($urandom_range(0, 255)); end
    do_capture(4, 0, 1'b0, 1'b0);
    release_frame(1'b0);
  endtask

  task automatic test_reset_post();
    configure(4, 0, 1'b0, 1, 128, 8);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) push($urandom_range(0, 255), $urandom_range(0, 255));
    push(110, 0);
    push(129, 0);
    push(1, 2);
    frame_done = 1'b1;
    push(3, 4);
    frame_done = 1'b0;
    push(5, 6);
    checks++;
    if (busy !== 1'b1 || frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL post_state: busy=%b frame_ready=%b expected 1/0", busy, frame_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: busy=%b frame_ready=%b expected 0/0", busy, frame_ready);
    end
    trig_mode = 2'd2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle: busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_rising();
    test_hysteresis();
    test_auto();
    test_falling();
    test_random();
    test_pause_clamp();
    test_single();
    test_reset_post();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
